// File: rtl/decode_inst_queue_pkg.sv
// Shared types and sequence-number age rule for the decode instruction queue.
// Optional same-cycle bypass is enabled with DECODE_INST_QUEUE_BYPASS_EN.
package decode_inst_queue_pkg;

    localparam int unsigned c_seq_max = 32;

    typedef struct packed {
        logic [31:0]          inst;
        logic [31:0]          pc;
        logic [c_seq_max-1:0] seq_num;
    } entry_t;

    // a is older than b when b lies in the half-window ahead of a
    function automatic logic seq_older(
        input logic [c_seq_max-1:0] a,
        input logic [c_seq_max-1:0] b,
        input int unsigned          bits
    );
        logic [c_seq_max-1:0] mask;
        logic [c_seq_max-1:0] half;
        logic [c_seq_max-1:0] diff;
        mask = (bits >= c_seq_max) ? '1 : ((c_seq_max'(1) << bits) - 1);
        half = c_seq_max'(1) << (bits - 1);
        diff = (b - a) & mask;
        return (diff != '0) && (diff < half);
    endfunction

endpackage

// File: rtl/seq_num_older.sv
// Wrap-aware sequence-number age comparator.
// Used by decode_inst_queue (see DECODE_INST_QUEUE_BYPASS_EN in the package).
module seq_num_older
    import decode_inst_queue_pkg::*;
#(
    parameter int p_bits = 5
) (
    input  logic [p_bits-1:0] a,
    input  logic [p_bits-1:0] b,
    output logic              older
);

    assign older = seq_older(c_seq_max'(a), c_seq_max'(b), p_bits);

endmodule

// File: rtl/decode_inst_queue.sv
// Circular fetch-to-decode instruction queue with squash-by-age suffix removal.
// Define DECODE_INST_QUEUE_BYPASS_EN for an empty-queue fetch-to-decode bypass.
module decode_inst_queue
    import decode_inst_queue_pkg::*;
#(
    parameter int p_depth        = 4,
    parameter int p_seq_num_bits = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          f_val,
    output logic                          f_rdy,
    input  logic [31:0]                   f_inst,
    input  logic [31:0]                   f_pc,
    input  logic [p_seq_num_bits-1:0]     f_seq_num,
    output logic                          d_val,
    input  logic                          d_rdy,
    output logic [31:0]                   d_inst,
    output logic [31:0]                   d_pc,
    output logic [p_seq_num_bits-1:0]     d_seq_num,
    input  logic                          squash_val,
    input  logic [p_seq_num_bits-1:0]     squash_seq_num,
    output logic [$clog2(p_depth+1)-1:0]  count
);

    localparam int c_pw = $clog2(p_depth);
    localparam int c_cw = $clog2(p_depth + 1);

    entry_t            mem [p_depth];
    logic [c_pw-1:0]   head;
    logic [c_pw-1:0]   tail;
    logic [c_cw-1:0]   cnt;
    logic              up;
    logic [p_depth-1:0] ent_young;
    logic              in_young;
    logic              enq;
    logic              deq;
    logic              wr;
    logic [c_cw-1:0]   keep_end;
    logic              found;
    logic [c_pw-1:0]   scan_idx;
    logic [c_pw-1:0]   head_n;
    logic [c_pw-1:0]   tail_n;
    logic [c_cw-1:0]   cnt_n;

    for (genvar i = 0; i < p_depth; i++) begin : g_age
        seq_num_older #(.p_bits(p_seq_num_bits)) u_age (
            .a     (squash_seq_num),
            .b     (mem[i].seq_num[p_seq_num_bits-1:0]),
            .older (ent_young[i])
        );
    end

    seq_num_older #(.p_bits(p_seq_num_bits)) u_age_in (
        .a     (squash_seq_num),
        .b     (f_seq_num),
        .older (in_young)
    );

    assign count = cnt;
    assign f_rdy = up && (cnt < c_cw'(p_depth));
    assign enq   = f_val && f_rdy;
    assign deq   = d_rdy && (cnt != '0);

`ifdef DECODE_INST_QUEUE_BYPASS_EN
    logic byp;
    assign byp       = enq && (cnt == '0) && !(squash_val && in_young);
    assign d_val     = (cnt != '0) || byp;
    assign d_inst    = byp ? f_inst : mem[head].inst;
    assign d_pc      = byp ? f_pc : mem[head].pc;
    assign d_seq_num = byp ? f_seq_num
                           : mem[head].seq_num[p_seq_num_bits-1:0];
    assign wr        = enq && !(squash_val && in_young) && !(byp && d_rdy);
`else
    assign d_val     = cnt != '0;
    assign d_inst    = mem[head].inst;
    assign d_pc      = mem[head].pc;
    assign d_seq_num = mem[head].seq_num[p_seq_num_bits-1:0];
    assign wr        = enq && !(squash_val && in_young);
`endif

    // first young entry past the dequeued head marks the removed suffix
    always_comb begin
        keep_end = cnt;
        found    = 1'b0;
        scan_idx = head;
        for (int k = 0; k < p_depth; k++) begin
            scan_idx = head + c_pw'(k);
            if (squash_val && !found &&
                c_cw'(k) >= c_cw'(deq) && c_cw'(k) < cnt &&
                ent_young[scan_idx]) begin
                keep_end = c_cw'(k);
                found    = 1'b1;
            end
        end
    end

    assign head_n = head + c_pw'(deq);
    assign tail_n = found ? head + c_pw'(keep_end) : tail;
    assign cnt_n  = keep_end - c_cw'(deq) + c_cw'(wr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            up   <= 1'b0;
        end else begin
            up   <= 1'b1;
            head <= head_n;
            tail <= tail_n + c_pw'(wr);
            cnt  <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[tail_n] <= '{inst: f_inst, pc: f_pc,
                             seq_num: c_seq_max'(f_seq_num)};
        end
    end

endmodule

// File: tb/tb_decode_inst_queue.sv
// Directed scoreboard bench for decode_inst_queue.
// Tracks DECODE_INST_QUEUE_BYPASS_EN to select the expected bypass behaviour.
module tb_decode_inst_queue;

`ifdef DECODE_INST_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  seq;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_val;
    logic        f_rdy;
    logic [31:0] f_inst;
    logic [31:0] f_pc;
    logic [4:0]  f_seq_num;
    logic        d_val;
    logic        d_rdy;
    logic [31:0] d_inst;
    logic [31:0] d_pc;
    logic [4:0]  d_seq_num;
    logic        squash_val;
    logic [4:0]  squash_seq_num;
    logic [2:0]  count;

    item_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    decode_inst_queue #(.p_depth(4), .p_seq_num_bits(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .f_val          (f_val),
        .f_rdy          (f_rdy),
        .f_inst         (f_inst),
        .f_pc           (f_pc),
        .f_seq_num      (f_seq_num),
        .d_val          (d_val),
        .d_rdy          (d_rdy),
        .d_inst         (d_inst),
        .d_pc           (d_pc),
        .d_seq_num      (d_seq_num),
        .squash_val     (squash_val),
        .squash_seq_num (squash_seq_num),
        .count          (count)
    );

    always #5 clk = ~clk;

    function automatic bit younger(input logic [4:0] x, input logic [4:0] s);
        logic [4:0] d;
        d = x - s;
        return (d != 5'd0) && (d < 5'd16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit fv, input logic [4:0] seq, input bit dr,
                       input bit sq, input logic [4:0] sqs);
        item_t it;
        item_t e;
        int    pre;
        bit    drop;
        bit    byp;
        it.inst = 32'hA500_0000 | 32'(seq);
        it.pc   = 32'h100 + 32'(seq) * 4;
        it.seq  = seq;
        f_val = fv;
        f_inst = it.inst;
        f_pc = it.pc;
        f_seq_num = seq;
        d_rdy = dr;
        squash_val = sq;
        squash_seq_num = sqs;
        #1;
        pre  = sb.size();
        drop = sq && younger(seq, sqs);
        byp  = BYP && fv && (pre == 0) && !drop;
        chk("count", 32'(count), 32'(pre));
        chk("f_rdy", 32'(f_rdy), 32'(pre < 4));
        chk("d_val", 32'(d_val), 32'((pre > 0) || byp));
        if (byp) begin
            chk("byp_seq", 32'(d_seq_num), 32'(seq));
            chk("byp_inst", d_inst, it.inst);
        end
        if (dr && pre > 0) begin
            e = sb.pop_front();
            chk("deq_seq", 32'(d_seq_num), 32'(e.seq));
            chk("deq_inst", d_inst, e.inst);
            chk("deq_pc", d_pc, e.pc);
        end
        if (sq) begin
            while (sb.size() > 0 && younger(sb[$].seq, sqs))
                void'(sb.pop_back());
        end
        if (fv && pre < 4 && !drop && !(byp && dr))
            sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            if (sb.size() > 0) cyc(1'b0, 5'd0, 1'b1, 1'b0, 5'd0);
        end
        cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        rst = 1'b0;
        f_val = 1'b0;
        f_inst = '0;
        f_pc = '0;
        f_seq_num = '0;
        d_rdy = 1'b0;
        squash_val = 1'b0;
        squash_seq_num = '0;
        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_d_val", 32'(d_val), 32'd0);
        chk("rst_f_rdy", 32'(f_rdy), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_f_rdy_edge", 32'(f_rdy), 32'd0);
        rst = 1'b1;
        #1;
        chk("f_rdy_before_edge", 32'(f_rdy), 32'd0);
        @(posedge clk);
        #1;
        chk("f_rdy_rise", 32'(f_rdy), 32'd1);

        // fill to full, offer while full, then drain in order
        for (int s = 0; s < 4; s++)
            cyc(1'b1, 5'(s), 1'b0, 1'b0, 5'd0);
        cyc(1'b1, 5'd4, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, 5'd4, 1'b1, 1'b0, 5'd0);
        cyc(1'b1, 5'd4, 1'b1, 1'b0, 5'd0);
        drain();

        // back-to-back stream across pointer wrap
        for (int s = 10; s < 20; s++)
            cyc(1'b1, 5'(s), 1'b1, 1'b0, 5'd0);
        drain();

        // squash suffix younger than 5
        for (int s = 4; s < 8; s++)
            cyc(1'b1, 5'(s), 1'b0, 1'b0, 5'd0);
        cyc(1'b0, 5'd0, 1'b0, 1'b1, 5'd5);
        drain();

        // wrap squash with simultaneous enqueue and dequeue
        cyc(1'b1, 5'd30, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, 5'd31, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, 5'd1, 1'b1, 1'b1, 5'd31);
        drain();

        // asynchronous reset mid-cycle with three entries
        for (int s = 20; s < 23; s++)
            cyc(1'b1, 5'(s), 1'b0, 1'b0, 5'd0);
        f_val = 1'b0;
        chk("pre_rst_count", 32'(count), 32'(sb.size()));
        #3;
        rst = 1'b0;
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_d_val", 32'(d_val), 32'd0);
        chk("async_f_rdy", 32'(f_rdy), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // empty-queue offer with decode ready
        cyc(1'b1, 5'd9, 1'b1, 1'b0, 5'd0);
        cyc(1'b0, 5'd0, 1'b1, 1'b0, 5'd0);
        cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
